imm_sequencer: RTL and testbench
================================

IMM_SEQUENCER -- requirements
Module: imm_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1 bit: 32-bit constant request present.
REQ-004 SHALL have port in_ready, output, 1 bit: sequencer can accept a request.
REQ-005 SHALL have port in_const, input, 32 bits: constant to materialize.
REQ-006 SHALL have port in_rd, input, 4 bits: destination register number.
REQ-007 SHALL have port out_valid, output, 1 bit: emitted instruction word valid.
REQ-008 SHALL have port out_ready, input, 1 bit: consumer accepts the current word.
REQ-009 SHALL have port out_instr, output, 24 bits: instruction field word, in the layout the immediate extender decodes.
REQ-010 SHALL have port out_immsrc, output, 2 bits: always 2'b11 while out_valid.
REQ-011 SHALL have port out_is_movt, output, 1 bit: word is MOVT.
REQ-012 SHALL have port out_is_movm, output, 1 bit: word is MOVM.
REQ-013 SHALL have port out_last, output, 1 bit: final word of the current sequence.

Function
REQ-014 SHALL split in_const into three fields: L = [11:0], M = [19:12], H = [31:20].
REQ-015 SHALL emit MOV, MOVM and MOVT words in that order, with out_instr[15:12] = rd and all unused bits zero.
REQ-016 MOV word SHALL be: out_instr[11:0] = L; is_movt = 0; is_movm = 0.
REQ-017 MOVM word SHALL be: out_instr[7:0] = M, out_instr[11:8] = 0; is_movm = 1.
REQ-018 MOVT word SHALL be: out_instr[11:0] = H; is_movt = 1.
REQ-019 SHALL implement states IDLE, S_MOV, S_MOVM, S_MOVT.
REQ-020 IDLE: in_ready = 1 and out_valid = 0; on in_valid, capture in_const and in_rd and go to S_MOV in the next cycle.
REQ-021 Latency SHALL be exactly one cycle from input handshake to first out_valid.
REQ-022 In any S_* state, in_ready SHALL be 0, and requests SHALL NOT be captured.
REQ-023 While out_valid = 1 and out_ready = 0, all out_* signals SHALL hold stable.
REQ-024 On an out handshake, the FSM SHALL advance to the next emitted state, or to IDLE if out_last = 1.
REQ-025 out_last SHALL be 1 exactly on the final word of the sequence.
REQ-026 All outputs SHALL be registered, with no combinational path from in_* or out_ready to out_*.
REQ-027 The back-to-back rate SHALL be one idle cycle (IDLE) between sequences.

Reset
REQ-028 On reset, the FSM SHALL go to IDLE; in_ready = 1; out_valid = 0; out_instr = 0; out_immsrc = 0; out_is_movt = 0; out_is_movm = 0; out_last = 0.
REQ-029 Reset during a sequence SHALL abandon it with no further words emitted, and captured data SHALL be cleared to 0.
REQ-030 Reset simultaneous with in_valid SHALL NOT capture the request.

Configuration
REQ-031 With macro IMM_SEQ_ZERO_SKIP_EN defined, the MOVM word SHALL be skipped when M = 0, and the MOVT word SHALL be skipped when H = 0, because MOV clears upper bits.
REQ-032 With IMM_SEQ_ZERO_SKIP_EN defined, out_last SHALL mark the last non-skipped word, and MOV SHALL always be emitted.
REQ-033 Without IMM_SEQ_ZERO_SKIP_EN, all three words SHALL always be emitted, with out_last on MOVT.

Verification
REQ-034 const = 0x12345678, rd = 3, out_ready = 1 -> words 0x003678 (MOV), 0x003045 (MOVM), 0x003123 (MOVT, last), on consecutive cycles starting 1 cycle after accept.
REQ-035 const = 0x00000ABC, rd = 1, skip enabled -> single MOV word 0x001ABC with out_last = 1; skip disabled -> 3 words, last being MOVT with 0x001000.
REQ-036 out_ready held low 5 cycles on the MOVM word -> out_instr stable throughout; in_ready = 0; next word appears the cycle after out_ready rises.
REQ-037 reset asserted while in S_MOVM -> next cycle out_valid = 0, in_ready = 1, state IDLE; a new request is accepted normally.
REQ-038 in_valid held high across two requests -> second is captured only in IDLE after first out_last handshake, with no lost or duplicated words.
REQ-039 const = 0xFFF00000, skip enabled -> MOV 0x000000 then MOVT 0x000FFF (last); MOVM skipped.

Source files
------------

// File: rtl/imm_sequencer.sv
// rtl/imm_sequencer.sv - Expands a 32-bit constant into MOV/MOVM/MOVT words; IMM_SEQ_ZERO_SKIP_EN drops zero-field words.
module imm_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_const,
    input  logic [3:0]  in_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_instr,
    output logic [1:0]  out_immsrc,
    output logic        out_is_movt,
    output logic        out_is_movm,
    output logic        out_last
);

    typedef enum logic [1:0] {IDLE, S_MOV, S_MOVM, S_MOVT} state_t;

    state_t      state, state_next;
    logic [31:0] const_q, const_next;
    logic [3:0]  rd_q, rd_next;
    logic        skip_m, skip_h;

    logic        in_ready_next;
    logic        valid_next;
    logic [23:0] instr_next;
    logic [1:0]  immsrc_next;
    logic        movt_next;
    logic        movm_next;
    logic        last_next;

`ifdef IMM_SEQ_ZERO_SKIP_EN
    // MOV clears the upper bits, so a zero middle/high field needs no word
    assign skip_m = (const_next[19:12] == 8'd0);
    assign skip_h = (const_next[31:20] == 12'd0);
`else
    assign skip_m = 1'b0;
    assign skip_h = 1'b0;
`endif

    always_comb begin
        state_next = state;
        const_next = const_q;
        rd_next    = rd_q;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    const_next = in_const;
                    rd_next    = in_rd;
                    state_next = S_MOV;
                end
            end
            S_MOV: begin
                if (out_ready) begin
                    if (!skip_m)      state_next = S_MOVM;
                    else if (!skip_h) state_next = S_MOVT;
                    else              state_next = IDLE;
                end
            end
            S_MOVM: begin
                if (out_ready) state_next = skip_h ? IDLE : S_MOVT;
            end
            S_MOVT: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output words are computed for the state being entered and then registered
    always_comb begin
        in_ready_next = (state_next == IDLE);
        valid_next    = 1'b0;
        instr_next    = 24'd0;
        immsrc_next   = 2'b00;
        movt_next     = 1'b0;
        movm_next     = 1'b0;
        last_next     = 1'b0;
        case (state_next)
            S_MOV: begin
                valid_next  = 1'b1;
                immsrc_next = 2'b11;
                instr_next  = {8'd0, rd_next, const_next[11:0]};
                last_next   = skip_m && skip_h;
            end
            S_MOVM: begin
                valid_next  = 1'b1;
                immsrc_next = 2'b11;
                instr_next  = {8'd0, rd_next, 4'd0, const_next[19:12]};
                movm_next   = 1'b1;
                last_next   = skip_h;
            end
            S_MOVT: begin
                valid_next  = 1'b1;
                immsrc_next = 2'b11;
                instr_next  = {8'd0, rd_next, const_next[31:20]};
                movt_next   = 1'b1;
                last_next   = 1'b1;
            end
            default: begin
                valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            const_q     <= 32'd0;
            rd_q        <= 4'd0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_instr   <= 24'd0;
            out_immsrc  <= 2'b00;
            out_is_movt <= 1'b0;
            out_is_movm <= 1'b0;
            out_last    <= 1'b0;
        end else begin
            state       <= state_next;
            const_q     <= const_next;
            rd_q        <= rd_next;
            in_ready    <= in_ready_next;
            out_valid   <= valid_next;
            out_instr   <= instr_next;
            out_immsrc  <= immsrc_next;
            out_is_movt <= movt_next;
            out_is_movm <= movm_next;
            out_last    <= last_next;
        end
    end

endmodule

// File: tb/tb_imm_sequencer.sv
// tb/tb_imm_sequencer.sv - Self-checking bench for imm_sequencer: vector table, corner sequences, random vs model.
module tb_imm_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_const;
    logic [3:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_instr;
    logic [1:0]  out_immsrc;
    logic        out_is_movt;
    logic        out_is_movm;
    logic        out_last;

    imm_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_const   (in_const),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_immsrc (out_immsrc),
        .out_is_movt(out_is_movt),
        .out_is_movm(out_is_movm),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] instr;
        logic        movt;
        logic        movm;
        logic        last;
    } word_t;

    typedef struct {
        logic [31:0] c;
        logic [3:0]  rd;
        int          n;
        word_t       w0;
        word_t       w1;
        word_t       w2;
    } vec_t;

    int    n_checks = 0;
    int    n_errors = 0;
    word_t exp_q[$];
    vec_t  vecs[6];
    bit    skip_en;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic word_t mk(input logic [23:0] instr, input logic movt, input logic movm, input logic last);
        word_t w;
        w.instr = instr;
        w.movt  = movt;
        w.movm  = movm;
        w.last  = last;
        return w;
    endfunction

    function automatic logic [31:0] act_word();
        return {3'd0, out_instr, out_is_movt, out_is_movm, out_last, out_immsrc};
    endfunction

    function automatic logic [31:0] exp_word(input word_t w);
        return {3'd0, w.instr, w.movt, w.movm, w.last, 2'b11};
    endfunction

    // Reference: list the fields that must be materialized, drop zero fields when skipping
    task automatic build_model(input logic [31:0] c, input logic [3:0] rd);
        int l, m, h, r;
        l = int'(c[11:0]);
        m = int'(c[19:12]);
        h = int'(c[31:20]);
        r = int'(rd);
        exp_q.delete();
        exp_q.push_back(mk(24'(r * 4096 + l), 1'b0, 1'b0, 1'b0));
        if (!(skip_en && m == 0)) exp_q.push_back(mk(24'(r * 4096 + m), 1'b0, 1'b1, 1'b0));
        if (!(skip_en && h == 0)) exp_q.push_back(mk(24'(r * 4096 + h), 1'b1, 1'b0, 1'b0));
        exp_q[exp_q.size() - 1].last = 1'b1;
    endtask

    // Starts from IDLE, issues one request and drains exp_q with random back-pressure
    task automatic run_req(input logic [31:0] c, input logic [3:0] rd, input int stall_pct);
        int cycles;
        bit rdy;
        chk("pre_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_const = c;
        in_rd    = rd;
        step();
        in_valid = 1'b0;
        in_const = $urandom;
        in_rd    = 4'($urandom);
        chk("latency_valid", 32'(out_valid), 32'd1);
        cycles = 0;
        while (exp_q.size() > 0 && cycles < 60) begin
            chk("seq_valid", 32'(out_valid), 32'd1);
            chk("seq_in_ready", 32'(in_ready), 32'd0);
            chk("seq_word", act_word(), exp_word(exp_q[0]));
            rdy = ($urandom_range(99) >= stall_pct);
            out_ready = rdy;
            step();
            if (rdy) void'(exp_q.pop_front());
            cycles++;
        end
        if (exp_q.size() != 0) chk("seq_timeout", 32'(exp_q.size()), 32'd0);
        out_ready = 1'b0;
        chk("post_idle_valid", 32'(out_valid), 32'd0);
        chk("post_idle_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_outs"}, act_word(), 32'd0);
    endtask

    initial begin
        word_t a[7];
        logic [31:0] c;
`ifdef IMM_SEQ_ZERO_SKIP_EN
        skip_en = 1'b1;
`else
        skip_en = 1'b0;
`endif
        vecs[0] = '{32'h12345678, 4'd3, 3, mk(24'h003678,0,0,0), mk(24'h003045,0,1,0), mk(24'h003123,1,0,1)};
        vecs[3] = '{32'hFFFFFFFF, 4'd15, 3, mk(24'h00FFFF,0,0,0), mk(24'h00F0FF,0,1,0), mk(24'h00FFFF,1,0,1)};
`ifdef IMM_SEQ_ZERO_SKIP_EN
        vecs[1] = '{32'h00000ABC, 4'd1, 1, mk(24'h001ABC,0,0,1), mk(0,0,0,0), mk(0,0,0,0)};
        vecs[2] = '{32'hFFF00000, 4'd0, 2, mk(24'h000000,0,0,0), mk(24'h000FFF,1,0,1), mk(0,0,0,0)};
        vecs[4] = '{32'h000FF000, 4'd5, 2, mk(24'h005000,0,0,0), mk(24'h0050FF,0,1,1), mk(0,0,0,0)};
        vecs[5] = '{32'h00000000, 4'd7, 1, mk(24'h007000,0,0,1), mk(0,0,0,0), mk(0,0,0,0)};
`else
        vecs[1] = '{32'h00000ABC, 4'd1, 3, mk(24'h001ABC,0,0,0), mk(24'h001000,0,1,0), mk(24'h001000,1,0,1)};
        vecs[2] = '{32'hFFF00000, 4'd0, 3, mk(24'h000000,0,0,0), mk(24'h000000,0,1,0), mk(24'h000FFF,1,0,1)};
        vecs[4] = '{32'h000FF000, 4'd5, 3, mk(24'h005000,0,0,0), mk(24'h0050FF,0,1,0), mk(24'h005000,1,0,1)};
        vecs[5] = '{32'h00000000, 4'd7, 3, mk(24'h007000,0,0,0), mk(24'h007000,0,1,0), mk(24'h007000,1,0,1)};
`endif

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_const  = 32'd0;
        in_rd     = 4'd0;
        out_ready = 1'b0;
        step();
        step();
        check_reset_state("reset");
        reset = 1'b0;
        step();

        foreach (vecs[i]) begin
            exp_q.delete();
            exp_q.push_back(vecs[i].w0);
            if (vecs[i].n > 1) exp_q.push_back(vecs[i].w1);
            if (vecs[i].n > 2) exp_q.push_back(vecs[i].w2);
            run_req(vecs[i].c, vecs[i].rd, 0);
        end

        // Back-pressure on MOVM for five cycles
        in_valid = 1'b1; in_const = 32'h12345678; in_rd = 4'd3;
        step();
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("stall_word", act_word(), exp_word(mk(24'h003045, 0, 1, 0)));
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            step();
        end
        chk("stall_hold_end", act_word(), exp_word(mk(24'h003045, 0, 1, 0)));
        out_ready = 1'b1;
        step();
        chk("stall_next_word", act_word(), exp_word(mk(24'h003123, 1, 0, 1)));
        step();
        out_ready = 1'b0;
        chk("stall_done", 32'(out_valid), 32'd0);

        // Reset while MOVM is presented abandons the sequence
        in_valid = 1'b1; in_const = 32'h12345678; in_rd = 4'd3;
        step();
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("pre_rst_movm", act_word(), exp_word(mk(24'h003045, 0, 1, 0)));
        out_ready = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_state("mid_rst");
        out_ready = 1'b1;
        step();
        chk("mid_rst_no_words", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        build_model(32'hCAFE1234, 4'd9);
        run_req(32'hCAFE1234, 4'd9, 0);

        // Reset together with in_valid must not capture
        reset = 1'b1; in_valid = 1'b1; in_const = 32'h12345678;
        step();
        reset = 1'b0; in_valid = 1'b0;
        check_reset_state("rst_valid");
        step();
        chk("rst_valid_nocap", 32'(out_valid), 32'd0);

        // in_valid held across two requests: one idle cycle, no lost or repeated words
        a[0] = mk(24'h003678, 0, 0, 0);
        a[1] = mk(24'h003045, 0, 1, 0);
        a[2] = mk(24'h003123, 1, 0, 1);
        a[3] = mk(24'h000000, 0, 0, 0);
        a[4] = mk(24'h00AFFF, 0, 0, 0);
        a[5] = mk(24'h00A0FF, 0, 1, 0);
        a[6] = mk(24'h00AFFF, 1, 0, 1);
        in_valid = 1'b1; in_const = 32'h12345678; in_rd = 4'd3;
        step();
        in_const = 32'hFFFFFFFF; in_rd = 4'd10;
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k == 4) in_valid = 1'b0;
            if (k == 3) begin
                chk("b2b_idle_valid", 32'(out_valid), 32'd0);
                chk("b2b_idle_ready", 32'(in_ready), 32'd1);
            end else begin
                chk("b2b_word", act_word(), exp_word(a[k]));
            end
            step();
        end
        out_ready = 1'b0;
        chk("b2b_end", 32'(out_valid), 32'd0);

        // Randomized requests against the reference model
        for (int k = 0; k < 40; k++) begin
            c[11:0]  = 12'($urandom);
            c[19:12] = ($urandom_range(3) == 0) ? 8'd0 : 8'($urandom);
            c[31:20] = ($urandom_range(3) == 0) ? 12'd0 : 12'($urandom);
            repeat ($urandom_range(2)) step();
            build_model(c, 4'($urandom));
            run_req(c, exp_q[0].instr[15:12], 30);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
